dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU pipeline and the NIC, with NIC burst lock and a one-cycle read-return tag.
// Optional DMEM_ARB_ROUND_ROBIN_EN: round-robin tie-break in ARB instead of fixed CPU priority.
module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  nic_req,
  input  logic                  nic_we,
  input  logic                  nic_lock,
  input  logic [ADDR_WIDTH-1:0] nic_addr,
  input  logic [DATA_WIDTH-1:0] nic_wdata,
  output logic                  nic_gnt,
  output logic                  nic_rvalid,
  output logic [DATA_WIDTH-1:0] nic_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  typedef enum logic {
    ARB       = 1'b0,
    NIC_BURST = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic             last_nic, last_nic_nxt;   // 1: NIC won the most recent grant
  logic             rtag_cpu, rtag_cpu_nxt;
  logic             rtag_nic, rtag_nic_nxt;
  logic             cpu_win, nic_win;
  logic             burst_hold;

  // State register; a clock edge with rst high discards everything this cycle granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      burst_cnt <= '0;
      last_nic  <= 1'b1;
      rtag_cpu  <= 1'b0;
      rtag_nic  <= 1'b0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
      last_nic  <= last_nic_nxt;
      rtag_cpu  <= rtag_cpu_nxt;
      rtag_nic  <= rtag_nic_nxt;
    end
  end

  // Locked burst continues only while the NIC keeps both req and lock high.
  assign burst_hold = (state == NIC_BURST) && nic_req && nic_lock;

  // Winner selection; purely combinational so a lone requester is granted immediately.
  always_comb begin
    cpu_win = 1'b0;
    nic_win = 1'b0;
    if (burst_hold) begin
      if ((burst_cnt == BURST_MAX) && cpu_req) begin
        cpu_win = 1'b1;
      end else begin
        nic_win = 1'b1;
      end
    end else if (cpu_req && nic_req) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      cpu_win = last_nic;
      nic_win = ~last_nic;
`else
      cpu_win = 1'b1;
`endif
    end else begin
      cpu_win = cpu_req;
      nic_win = nic_req;
    end
  end

  // Next-state: FSM, burst counter, last winner and read-return tag.
  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    last_nic_nxt  = last_nic;
    rtag_cpu_nxt  = cpu_win & ~cpu_we;
    rtag_nic_nxt  = nic_win & ~nic_we;
    if (cpu_win) begin
      last_nic_nxt = 1'b0;
    end else if (nic_win) begin
      last_nic_nxt = 1'b1;
    end
    case (state)
      ARB: begin
        if (nic_win && nic_lock) begin
          state_nxt     = NIC_BURST;
          burst_cnt_nxt = CNT_W'(1);
        end
      end
      NIC_BURST: begin
        if (!burst_hold) begin
          state_nxt     = ARB;
          burst_cnt_nxt = '0;
        end else if (cpu_win) begin
          burst_cnt_nxt = '0;
        end else if (burst_cnt < BURST_MAX) begin
          burst_cnt_nxt = burst_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt     = ARB;
        burst_cnt_nxt = '0;
      end
    endcase
  end

  // Outputs: grants, memory-port mux (zero when idle), stall and gated read returns.
  always_comb begin
    cpu_gnt    = cpu_win;
    nic_gnt    = nic_win;
    cpu_stall  = cpu_req & ~cpu_win;
    mem_en     = cpu_win | nic_win;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (cpu_win) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (nic_win) begin
      mem_we    = nic_we;
      mem_addr  = nic_addr;
      mem_wdata = nic_wdata;
    end
    cpu_rvalid = rtag_cpu & ~rst;
    nic_rvalid = rtag_nic & ~rst;
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    nic_rdata  = nic_rvalid ? mem_rdata : '0;
  end

endmodule
